// File: rtl/ifm_scan_ctrl.sv
// Snake-order 3x3 window scanner: fetches IFM pixels and issues ALL/RIGHT/DOWN/LEFT commands.
// Optional stall counter output when IFM_SCAN_STALL_CNT_EN is defined.
module ifm_scan_ctrl #(
    parameter int IFM_W  = 8,
    parameter int IFM_H  = 8,
    parameter int ADDR_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    pe_ready,
    output logic                    mem_req,
    output logic [ADDR_W-1:0]       mem_addr,
    input  logic signed [7:0]       mem_rdata,
    output logic [2:0]              ifm_read,
    output logic [2:0][31:0]        ifm_input,
    output logic                    busy,
    output logic                    done
`ifdef IFM_SCAN_STALL_CNT_EN
    ,
    output logic [15:0]             stall_cnt
`endif
);

    localparam logic [2:0] CMD_ALL   = 3'b111;
    localparam logic [2:0] CMD_RIGHT = 3'b001;
    localparam logic [2:0] CMD_DOWN  = 3'b010;
    localparam logic [2:0] CMD_LEFT  = 3'b100;
    localparam logic [7:0] COL_LAST  = 8'(IFM_W - 3);
    localparam logic [7:0] ROW_LAST  = 8'(IFM_H - 3);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_ISSUE, S_DONE} state_t;

    state_t      r_state, w_next_state;
    logic [7:0]  r_row, r_col;
    logic        r_dir;             // 0: moving right, 1: moving left
    logic [2:0]  r_cmd;
    logic [3:0]  r_cnt;
    logic [1:0]  r_ki, r_kj;
    logic        r_rd_vld;
    logic [3:0]  r_rd_idx;
    logic [7:0]  r_pix [0:8];

    logic        w_fetch_last;
    logic [7:0]  w_nr, w_nc;
    logic        w_ndir, w_at_edge, w_scan_end;
    logic [2:0]  w_next_cmd;
    logic [ADDR_W-1:0] w_row, w_col;
    logic [31:0] w_pk0, w_pk1, w_pk2;

    assign w_fetch_last = (r_cnt == ((r_cmd == CMD_ALL) ? 4'd8 : 4'd2));
    assign w_pk0 = {8'h00, r_pix[0], r_pix[1], r_pix[2]};
    assign w_pk1 = {8'h00, r_pix[3], r_pix[4], r_pix[5]};
    assign w_pk2 = {8'h00, r_pix[6], r_pix[7], r_pix[8]};

    // Position after the pending command, and what comes next from there
    always_comb begin
        w_nr   = r_row;
        w_nc   = r_col;
        w_ndir = r_dir;
        case (r_cmd)
            CMD_RIGHT: w_nc = r_col + 8'd1;
            CMD_LEFT:  w_nc = r_col - 8'd1;
            CMD_DOWN: begin
                w_nr   = r_row + 8'd1;
                w_ndir = ~r_dir;
            end
            default: ;
        endcase
        w_at_edge  = w_ndir ? (w_nc == 8'd0) : (w_nc == COL_LAST);
        w_scan_end = w_at_edge && (w_nr == ROW_LAST);
        w_next_cmd = w_at_edge ? CMD_DOWN : (w_ndir ? CMD_LEFT : CMD_RIGHT);
    end

    always_comb begin
        w_row = ADDR_W'(r_row) + ADDR_W'(r_cnt);
        w_col = ADDR_W'(r_col) - ADDR_W'(1);
        case (r_cmd)
            CMD_ALL: begin
                w_row = ADDR_W'(r_row) + ADDR_W'(r_ki);
                w_col = ADDR_W'(r_col) + ADDR_W'(r_kj);
            end
            CMD_RIGHT: w_col = ADDR_W'(r_col) + ADDR_W'(3);
            CMD_DOWN: begin
                w_row = ADDR_W'(r_row) + ADDR_W'(3);
                w_col = ADDR_W'(r_col) + ADDR_W'(r_cnt);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next_state = S_FETCH;
            S_FETCH: if (w_fetch_last) w_next_state = S_WAIT;
            S_WAIT:  w_next_state = S_ISSUE;
            S_ISSUE: if (pe_ready) w_next_state = w_scan_end ? S_DONE : S_FETCH;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_addr  = '0;
        ifm_read  = 3'b000;
        ifm_input = '0;
        busy      = (r_state == S_FETCH) || (r_state == S_WAIT) || (r_state == S_ISSUE);
        done      = (r_state == S_DONE);
        if (r_state == S_FETCH) begin
            mem_req  = 1'b1;
            mem_addr = w_row * ADDR_W'(IFM_W) + w_col;
        end
        if (r_state == S_ISSUE && pe_ready) begin
            ifm_read = r_cmd;
            case (r_cmd)
                CMD_ALL:   ifm_input = {w_pk2, w_pk1, w_pk0};
                CMD_RIGHT: ifm_input[0] = w_pk0;
                CMD_DOWN:  ifm_input[1] = w_pk0;
                default:   ifm_input[2] = w_pk0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_row    <= '0;
            r_col    <= '0;
            r_dir    <= 1'b0;
            r_cmd    <= CMD_ALL;
            r_cnt    <= '0;
            r_ki     <= '0;
            r_kj     <= '0;
            r_rd_vld <= 1'b0;
            r_rd_idx <= '0;
        end else begin
            r_rd_vld <= mem_req;
            r_rd_idx <= r_cnt;
            case (r_state)
                S_IDLE: if (start) begin
                    r_row <= '0;
                    r_col <= '0;
                    r_dir <= 1'b0;
                    r_cmd <= CMD_ALL;
                    r_cnt <= '0;
                    r_ki  <= '0;
                    r_kj  <= '0;
                end
                S_FETCH: begin
                    if (w_fetch_last) begin
                        r_cnt <= '0;
                        r_ki  <= '0;
                        r_kj  <= '0;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                        if (r_kj == 2'd2) begin
                            r_kj <= '0;
                            r_ki <= r_ki + 2'd1;
                        end else begin
                            r_kj <= r_kj + 2'd1;
                        end
                    end
                end
                S_ISSUE: if (pe_ready) begin
                    r_row <= w_nr;
                    r_col <= w_nc;
                    r_dir <= w_ndir;
                    r_cmd <= w_next_cmd;
                end
                default: ;
            endcase
        end
    end

    // Read data lands one cycle after its strobe; r_rd_vld is cleared by reset
    always_ff @(posedge clk) begin
        if (r_rd_vld) r_pix[r_rd_idx] <= mem_rdata;
    end

`ifdef IFM_SCAN_STALL_CNT_EN
    logic [15:0] r_stall_cnt;
    always_ff @(posedge clk) begin
        if (rst)
            r_stall_cnt <= '0;
        else if (r_state == S_IDLE && start)
            r_stall_cnt <= '0;
        else if (r_state == S_ISSUE && !pe_ready && r_stall_cnt != 16'hFFFF)
            r_stall_cnt <= r_stall_cnt + 16'd1;
    end
    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_ifm_scan_ctrl.sv
// Scoreboard bench for ifm_scan_ctrl: 4x4 instance (main) and 3x5 instance (narrow IFM).
module tb_ifm_scan_ctrl;

    localparam logic [2:0] C_ALL = 3'b111, C_RIGHT = 3'b001, C_DOWN = 3'b010, C_LEFT = 3'b100;
    localparam logic [95:0] A_ALL   = {32'h0008090A, 32'h00040506, 32'h00000102};
    localparam logic [95:0] A_RIGHT = {32'h0, 32'h0, 32'h0003070B};
    localparam logic [95:0] A_DOWN  = {32'h0, 32'h000D0E0F, 32'h0};
    localparam logic [95:0] A_LEFT  = {32'h0004080C, 32'h0, 32'h0};
    localparam logic [95:0] B_ALL   = {32'h00060708, 32'h00030405, 32'h00000102};
    localparam logic [95:0] B_DOWN1 = {32'h0, 32'h00090A0B, 32'h0};
    localparam logic [95:0] B_DOWN2 = {32'h0, 32'h000C0D0E, 32'h0};

    typedef struct {
        logic [2:0]  cmd;
        logic [95:0] words;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_a = 1'b0, start_b = 1'b0;
    logic pe_a = 1'b1, pe_b = 1'b1;
    logic a_req, b_req, a_busy, b_busy, a_done, b_done;
    logic [15:0] a_addr, b_addr;
    logic signed [7:0] a_rdata, b_rdata;
    logic [2:0] a_read, b_read;
    logic [2:0][31:0] a_in, b_in;
`ifdef IFM_SCAN_STALL_CNT_EN
    logic [15:0] a_stall, b_stall;
`endif

    int cyc = 0;
    int checks = 0, failures = 0;
    bit mon_en = 1'b0;
    exp_t qa[$], qb[$];
    exp_t ea, eb;
    int a_done_n = 0, b_done_n = 0, a_done_cyc = -1, b_done_cyc = -1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ifm_scan_ctrl #(.IFM_W(4), .IFM_H(4), .ADDR_W(16)) u_dut (
        .clk(clk), .rst(rst), .start(start_a), .pe_ready(pe_a),
        .mem_req(a_req), .mem_addr(a_addr), .mem_rdata(a_rdata),
        .ifm_read(a_read), .ifm_input(a_in), .busy(a_busy), .done(a_done)
`ifdef IFM_SCAN_STALL_CNT_EN
        , .stall_cnt(a_stall)
`endif
    );

    ifm_scan_ctrl #(.IFM_W(3), .IFM_H(5), .ADDR_W(16)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .pe_ready(pe_b),
        .mem_req(b_req), .mem_addr(b_addr), .mem_rdata(b_rdata),
        .ifm_read(b_read), .ifm_input(b_in), .busy(b_busy), .done(b_done)
`ifdef IFM_SCAN_STALL_CNT_EN
        , .stall_cnt(b_stall)
`endif
    );

    // Memory model: p(addr) = addr, garbage when not strobed
    always @(posedge clk) begin
        a_rdata <= a_req ? a_addr[7:0] : 8'hA5;
        b_rdata <= b_req ? b_addr[7:0] : 8'h5A;
    end

    always @(negedge clk) if (mon_en) begin
        checks++;
        if (a_read === 3'b000) begin
            if (a_in !== '0) begin
                failures++;
                $display("FAIL keep_zero_a cyc=%0d got=%h want=0", cyc, a_in);
            end
        end else if (qa.size() == 0) begin
            failures++;
            $display("FAIL unexpected_cmd_a cyc=%0d got=%b want=none", cyc, a_read);
        end else begin
            ea = qa.pop_front();
            if (a_read !== ea.cmd || a_in !== ea.words || cyc != ea.cyc) begin
                failures++;
                $display("FAIL cmd_a got=%b/%h@%0d want=%b/%h@%0d", a_read, a_in, cyc, ea.cmd, ea.words, ea.cyc);
            end
        end
        if (a_done === 1'b1) begin a_done_n++; a_done_cyc = cyc; end
    end

    always @(negedge clk) if (mon_en) begin
        checks++;
        if (b_read === 3'b000) begin
            if (b_in !== '0) begin
                failures++;
                $display("FAIL keep_zero_b cyc=%0d got=%h want=0", cyc, b_in);
            end
        end else if (qb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_cmd_b cyc=%0d got=%b want=none", cyc, b_read);
        end else begin
            eb = qb.pop_front();
            if (b_read !== eb.cmd || b_in !== eb.words || cyc != eb.cyc) begin
                failures++;
                $display("FAIL cmd_b got=%b/%h@%0d want=%b/%h@%0d", b_read, b_in, cyc, eb.cmd, eb.words, eb.cyc);
            end
        end
        if (b_done === 1'b1) begin b_done_n++; b_done_cyc = cyc; end
    end

    task automatic wait_until(input int n);
        while (cyc < n) begin @(posedge clk); #1; end
    endtask

    // Returns the cycle number of the cycle right after the edge that samples start
    task automatic do_start(input bit sel_b, output int n0);
        @(posedge clk); #1;
        if (sel_b) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0; start_b = 1'b0;
        n0 = cyc;
    endtask

    task automatic push_full_a(input int n0);
        qa.push_back('{C_ALL,   A_ALL,   n0 + 10});
        qa.push_back('{C_RIGHT, A_RIGHT, n0 + 15});
        qa.push_back('{C_DOWN,  A_DOWN,  n0 + 20});
        qa.push_back('{C_LEFT,  A_LEFT,  n0 + 25});
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({a_read, a_in, a_req, a_addr, a_busy, a_done} !== '0) begin
            failures++;
            $display("FAIL reset_outs got=%b/%h/%b/%h/%b/%b want=all zero", a_read, a_in, a_req, a_addr, a_busy, a_done);
        end
`ifdef IFM_SCAN_STALL_CNT_EN
        checks++;
        if (a_stall !== 16'd0) begin failures++; $display("FAIL reset_stall got=%0d want=0", a_stall); end
`endif
        rst = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic test_scan();
        int n0, d0;
        d0 = a_done_n;
        do_start(1'b0, n0);
        push_full_a(n0);
        checks++;
        if (a_busy !== 1'b1) begin failures++; $display("FAIL scan_busy got=%b want=1", a_busy); end
        wait_until(n0 + 32);
        checks++;
        if (a_done_n != d0 + 1 || a_done_cyc != n0 + 26) begin
            failures++;
            $display("FAIL scan_done got=%0d@%0d want=%0d@%0d", a_done_n - d0, a_done_cyc, 1, n0 + 26);
        end
        checks++;
        if (qa.size() != 0 || a_busy !== 1'b0) begin
            failures++;
            $display("FAIL scan_end got=left%0d busy%b want=left0 busy0", qa.size(), a_busy);
        end
    endtask

    task automatic test_stall();
        int n0, d0;
        d0 = a_done_n;
        do_start(1'b0, n0);
        qa.push_back('{C_ALL,   A_ALL,   n0 + 10});
        qa.push_back('{C_RIGHT, A_RIGHT, n0 + 22});
        qa.push_back('{C_DOWN,  A_DOWN,  n0 + 27});
        qa.push_back('{C_LEFT,  A_LEFT,  n0 + 32});
        wait_until(n0 + 15);
        pe_a = 1'b0;
        wait_until(n0 + 22);
        pe_a = 1'b1;
        wait_until(n0 + 40);
        checks++;
        if (a_done_n != d0 + 1 || a_done_cyc != n0 + 33 || qa.size() != 0) begin
            failures++;
            $display("FAIL stall_done got=%0d@%0d left%0d want=1@%0d left0", a_done_n - d0, a_done_cyc, qa.size(), n0 + 33);
        end
`ifdef IFM_SCAN_STALL_CNT_EN
        checks++;
        if (a_stall !== 16'd7) begin failures++; $display("FAIL stall_cnt got=%0d want=7", a_stall); end
`endif
    endtask

    task automatic test_reset_mid();
        int n0, d0;
        d0 = a_done_n;
        do_start(1'b0, n0);
`ifdef IFM_SCAN_STALL_CNT_EN
        checks++;
        if (a_stall !== 16'd0) begin failures++; $display("FAIL stall_clr_on_start got=%0d want=0", a_stall); end
`endif
        qa.push_back('{C_ALL,   A_ALL,   n0 + 10});
        qa.push_back('{C_RIGHT, A_RIGHT, n0 + 15});
        wait_until(n0 + 17);
        checks++;
        if (a_req !== 1'b1 || a_addr !== 16'd14) begin
            failures++;
            $display("FAIL mid_fetch got=%b/%0d want=1/14", a_req, a_addr);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({a_read, a_in, a_req, a_addr, a_busy, a_done} !== '0) begin
            failures++;
            $display("FAIL mid_reset_outs got=%b/%h/%b/%h/%b/%b want=all zero", a_read, a_in, a_req, a_addr, a_busy, a_done);
        end
        wait_until(n0 + 30);
        checks++;
        if (a_busy !== 1'b0 || qa.size() != 0 || a_done_n != d0) begin
            failures++;
            $display("FAIL mid_idle got=busy%b left%0d done%0d want=busy0 left0 done0", a_busy, qa.size(), a_done_n - d0);
        end
        do_start(1'b0, n0);
        push_full_a(n0);
        wait_until(n0 + 32);
        checks++;
        if (a_done_n != d0 + 1 || a_done_cyc != n0 + 26 || qa.size() != 0) begin
            failures++;
            $display("FAIL restart_done got=%0d@%0d left%0d want=1@%0d left0", a_done_n - d0, a_done_cyc, qa.size(), n0 + 26);
        end
    endtask

    task automatic test_back_to_back();
        int n0, d0;
        d0 = a_done_n;
        do_start(1'b0, n0);
        push_full_a(n0);
        wait_until(n0 + 5);
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        wait_until(n0 + 20);
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        wait_until(n0 + 50);
        checks++;
        if (a_done_n != d0 + 1 || a_done_cyc != n0 + 26 || qa.size() != 0) begin
            failures++;
            $display("FAIL busy_start got=%0d@%0d left%0d want=1@%0d left0", a_done_n - d0, a_done_cyc, qa.size(), n0 + 26);
        end
    endtask

    task automatic test_narrow();
        int n0, d0;
        d0 = b_done_n;
        do_start(1'b1, n0);
        qb.push_back('{C_ALL,  B_ALL,   n0 + 10});
        qb.push_back('{C_DOWN, B_DOWN1, n0 + 15});
        qb.push_back('{C_DOWN, B_DOWN2, n0 + 20});
        wait_until(n0 + 30);
        checks++;
        if (b_done_n != d0 + 1 || b_done_cyc != n0 + 21 || qb.size() != 0 || b_busy !== 1'b0) begin
            failures++;
            $display("FAIL narrow_done got=%0d@%0d left%0d want=1@%0d left0", b_done_n - d0, b_done_cyc, qb.size(), n0 + 21);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        test_narrow();
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ifm_scan_ctrl.md
IFM_SCAN_CTRL -- requirements
Module: ifm_scan_ctrl

Interface
REQ-001 SHALL have parameter IFM_W, default 8, meaning IFM width in pixels (legal range 3..255).
REQ-002 SHALL have parameter IFM_H, default 8, meaning IFM height in pixels (legal range 3..255).
REQ-003 SHALL have parameter ADDR_W, default 16, meaning IFM memory byte-address width.
REQ-004 SHALL have one clock and a synchronous, active-high reset: clk  in  1  clock, rising edge; rst  in  1  sync active-high reset.
REQ-005 start  in  1  one-cycle request to scan one IFM; honoured only in IDLE.
REQ-006 pe_ready  in  1  consumer can accept a window command this cycle.
REQ-007 mem_req  out  1  IFM memory read strobe.
REQ-008 mem_addr  out  ADDR_W  byte address = row*IFM_W + col.
REQ-009 mem_rdata  in  8  signed pixel, valid the cycle after mem_req.
REQ-010 ifm_read  out  3  command: ALL=111, RIGHT=001, DOWN=010, LEFT=100, KEEP=000.
REQ-011 ifm_input  out  3x32 signed  packed pixel words; bits [31:24] always 0.
REQ-012 busy  out  1  high from the cycle after an accepted start until done.
REQ-013 done  out  1  one-cycle pulse after the last window command.

Function
REQ-014 SHALL traverse windows in snake order: row 0 left to right, DOWN, right to left, DOWN, ...; (IFM_H-2)*(IFM_W-2) commands total, the first being ALL.
REQ-015 SHALL use FSM states IDLE -> FETCH -> WAIT -> ISSUE -> (FETCH | DONE) -> IDLE.
REQ-016 FETCH SHALL assert mem_req for exactly N consecutive cycles, N=9 for ALL and N=3 for a shift; WAIT SHALL last one cycle to capture the last read.
REQ-017 ALL at window (r,c) SHALL pack word i = {8'h0, p(r+i,c), p(r+i,c+1), p(r+i,c+2)}; reads are issued row-major.
REQ-018 RIGHT SHALL fill word0 with column c+3, rows r..r+2, top row in [23:16]; words 1 and 2 SHALL be 0.
REQ-019 DOWN SHALL fill word1 with row r+3, columns c..c+2, leftmost column in [23:16]; words 0 and 2 SHALL be 0.
REQ-020 LEFT SHALL fill word2 with column c-1, rows r..r+2, top row in [23:16]; words 0 and 1 SHALL be 0.
REQ-021 In ISSUE with pe_ready=1, the block SHALL drive the command and words for exactly one cycle, then update (r,c).
REQ-022 In ISSUE with pe_ready=0, the block SHALL drive ifm_read=KEEP with all words 0 and hold its state; no command is ever repeated or lost.
REQ-023 Whenever ifm_read=KEEP, ifm_input SHALL be all zeros.
REQ-024 With pe_ready held at 1, ALL SHALL appear in the 11th cycle after the edge that samples start, and each later command 5 cycles after the previous one.
REQ-025 When the last window (row IFM_H-3) has issued, the block SHALL enter DONE: done=1 for one cycle, busy=0, then IDLE.
REQ-026 For IFM_W=3 the traversal SHALL contain no RIGHT/LEFT commands; for IFM_H=3 it SHALL contain no DOWN commands; for 3x3 it SHALL issue ALL only, then done.
REQ-027 A start asserted while busy SHALL be ignored.

Reset
REQ-028 On rst=1 at a rising edge, the FSM SHALL go to IDLE, even mid-scan; ifm_read=KEEP, ifm_input=0, mem_req=0, mem_addr=0, busy=0, done=0, and position counters=0.
REQ-029 A read returning in the cycle after reset SHALL be discarded.

Configuration
REQ-030 With macro IFM_SCAN_STALL_CNT_EN defined, the block SHALL add output stall_cnt (16 bits), which counts ISSUE cycles with pe_ready=0, saturates at 16'hFFFF, and clears on reset and on an accepted start.
REQ-031 Without IFM_SCAN_STALL_CNT_EN, the stall_cnt port and its logic SHALL NOT exist; all other behaviour SHALL be identical.

Verification (IFM_W=IFM_H=4, memory p(addr)=addr, pe_ready=1 unless stated)
REQ-032 start -> ALL with words 0x00000102, 0x00040506, 0x0008090A, 11 cycles after the start edge.
REQ-033 Continue -> RIGHT word0=0x0003070B; DOWN word1=0x000D0E0F; LEFT word2=0x0004080C; commands 5 cycles apart; done pulses once; exactly 4 commands in total.
REQ-034 pe_ready=0 for 7 cycles at the RIGHT issue -> KEEP with zero words for 7 cycles, then RIGHT once; stall_cnt=7 when IFM_SCAN_STALL_CNT_EN is defined.
REQ-035 rst pulse during the DOWN fetch -> next cycle in IDLE with all outputs at reset values; a following start restarts from ALL at (0,0).
REQ-036 IFM_W=3, IFM_H=5, start -> sequence ALL, DOWN, DOWN, then done.
REQ-037 start asserted again while busy -> no effect on the command sequence or on the cycle of the done pulse.
